// File: rtl/simple_uart_tx_ctrl_pkg.sv
// Shared FSM encodings and status constants for the UART transmit scheduler.
package simple_uart_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    TXC_IDLE = 2'd0,
    TXC_ARM  = 2'd1,
    TXC_BUSY = 2'd2
  } txc_state_e;

  localparam logic [1:0] UART_ST_IDLE    = 2'd0;
  localparam logic [1:0] UART_ST_PENDING = 2'd1;
  localparam logic [1:0] UART_ST_SENDING = 2'd2;

  function automatic logic [1:0] uart_status(input txc_state_e st, input logic q_empty);
    if (st == TXC_IDLE) return q_empty ? UART_ST_IDLE : UART_ST_PENDING;
    return (st == TXC_ARM) ? UART_ST_PENDING : UART_ST_SENDING;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO between the request arbiter and the transmit FSM; head word is
// visible combinationally so the FSM can capture it on the pop edge.
module uart_tx_fifo #(
  parameter int FIFO_AW = 2
) (
  input  logic               clk_i_w,
  input  logic               rst_i_w,
  input  logic               push_i,
  input  logic [7:0]         push_data_i,
  input  logic               pop_i,
  output logic [7:0]         pop_data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   level_o
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_LAST = (FIFO_AW + 1)'(DEPTH - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == LVL_FULL);
  assign empty_o    = (count_q == '0);
  assign level_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: contents are meaningless until counted in.
  always_ff @(posedge clk_i_w) begin
    if (do_push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/simple_uart_tx_ctrl.sv
// UART transmit scheduler: two-requester arbiter, byte FIFO, baud tick and send FSM.
// Build option: define UART_TX_FIXED_PRIO_EN for fixed req0 priority instead of round-robin.
module simple_uart_tx_ctrl
  import simple_uart_tx_ctrl_pkg::*;
#(
  parameter int BAUD_DIV    = 434,
  parameter int FIFO_AW     = 2,
  parameter int FRAME_TICKS = 11
) (
  input  logic             clk_i_w,
  input  logic             rst_i_w,
  input  logic             req0_valid_i_w,
  input  logic [7:0]       req0_data_i_w,
  output logic             req0_ready_o_w,
  input  logic             req1_valid_i_w,
  input  logic [7:0]       req1_data_i_w,
  output logic             req1_ready_o_w,
  output logic             baud_en_o_r,
  output logic             send_o_r,
  output logic [7:0]       schar_o_r,
  output logic             busy_o_r,
  output logic [FIFO_AW:0] fifo_level_o_w
);

  localparam int CNT_W  = $clog2(BAUD_DIV);
  localparam int TICK_W = $clog2(FRAME_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              baud_en_q;
  txc_state_e        state_q;
  logic [TICK_W-1:0] tick_q;
  logic              send_q;
  logic [7:0]        schar_q;
  logic              busy_q;

  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [7:0]        fifo_rdata, fifo_wdata;
  logic              grant0, grant1;

  // Arbiter: grants are combinational and suppressed whenever the FIFO is full.
`ifdef UART_TX_FIXED_PRIO_EN
  assign grant0 = !fifo_full && req0_valid_i_w;
  assign grant1 = !fifo_full && req1_valid_i_w && !req0_valid_i_w;
`else
  logic last_grant_q;

  assign grant0 = !fifo_full && req0_valid_i_w && (!req1_valid_i_w || last_grant_q);
  assign grant1 = !fifo_full && req1_valid_i_w && (!req0_valid_i_w || !last_grant_q);

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w)               last_grant_q <= 1'b1;
    else if (grant0 || grant1)  last_grant_q <= grant1;
  end
`endif

  assign req0_ready_o_w = grant0;
  assign req1_ready_o_w = grant1;
  assign fifo_push      = grant0 || grant1;
  assign fifo_wdata     = grant0 ? req0_data_i_w : req1_data_i_w;
  assign fifo_pop       = (state_q == TXC_IDLE) && !fifo_empty;

  uart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk_i_w     (clk_i_w),
    .rst_i_w     (rst_i_w),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level_o_w)
  );

  // Free-running baud divider, never realigned to traffic.
  assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      cnt_q     <= '0;
      baud_en_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      baud_en_q <= (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      state_q <= TXC_IDLE;
      tick_q  <= '0;
      send_q  <= 1'b0;
      schar_q <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_q != TXC_IDLE) || !fifo_empty;
      case (state_q)
        TXC_IDLE: begin
          if (!fifo_empty) begin
            schar_q <= fifo_rdata;
            send_q  <= 1'b1;
            state_q <= TXC_ARM;
          end
        end
        TXC_ARM: begin
          // Drop send on the edge closing the enabled cycle, so the sender sees it once.
          if (baud_en_q) begin
            send_q  <= 1'b0;
            tick_q  <= '0;
            state_q <= TXC_BUSY;
          end
        end
        TXC_BUSY: begin
          if (baud_en_q) begin
            if (tick_q == TICK_LAST) state_q <= TXC_IDLE;
            else                     tick_q  <= tick_q + 1'b1;
          end
        end
        default: state_q <= TXC_IDLE;
      endcase
    end
  end

  assign baud_en_o_r = baud_en_q;
  assign send_o_r    = send_q;
  assign schar_o_r   = schar_q;
  assign busy_o_r    = busy_q;

endmodule

// File: tb/tb_simple_uart_tx_ctrl.sv
// Randomized bench for simple_uart_tx_ctrl against a queue/edge-arithmetic reference model.
// Honors UART_TX_FIXED_PRIO_EN the same way as the design.
module tb_simple_uart_tx_ctrl;

  localparam int BD    = 4;
  localparam int FT    = 11;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [7:0]    d0 = 8'h00, d1 = 8'h00;
  logic          rdy0, rdy1, baud_en, send, busy;
  logic [7:0]    schar;
  logic [AW:0]   level;

  simple_uart_tx_ctrl #(.BAUD_DIV(BD), .FIFO_AW(AW), .FRAME_TICKS(FT)) dut (
    .clk_i_w        (clk),
    .rst_i_w        (rst),
    .req0_valid_i_w (v0),
    .req0_data_i_w  (d0),
    .req0_ready_o_w (rdy0),
    .req1_valid_i_w (v1),
    .req1_data_i_w  (d1),
    .req1_ready_o_w (rdy1),
    .baud_en_o_r    (baud_en),
    .send_o_r       (send),
    .schar_o_r      (schar),
    .busy_o_r       (busy),
    .fifo_level_o_w (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes in a queue, frame timing as edge-number arithmetic.
  // e = number of clock edges since reset release; baud tick visible after edges that are multiples of BD.
  logic [7:0] mq[$];
  bit         lg;
  bit         fv;
  int         e, p, s, free_e;
  logic [7:0] schar_m;
  bit         busy_m;
  bit         rec = 1'b0;
  int         tick_edges[$];
  logic [7:0] sent[$];

  function automatic bit active(input int x);
    return fv && (x >= p) && (x <= s + FT * BD);
  endfunction

  task automatic model_reset();
    mq.delete();
    lg = 1'b1; fv = 1'b0; e = 0; p = 0; s = 0; free_e = 0;
    schar_m = 8'h00; busy_m = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_baud"}, baud_en, 1'b0);
    chk({tag, "_send"}, send, 1'b0);
    chk({tag, "_schar"}, schar, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_level"}, level, 0);
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic apply_reset();
    #3;
    v0 = 1'b0; v1 = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive, compare, advance the model across the next edge.
  task automatic step(input int mode);
    bit full, g0, g1;
    case (mode)
      1: begin v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22; end
      2: begin v0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom);
               v1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom); end
      3: begin v0 = 1'b1; d0 = 8'hA5; v1 = 1'b0; end
      4: begin v0 = 1'b1; d0 = 8'($urandom); v1 = 1'b0; end
      5: begin v0 = ($urandom_range(0, 19) == 0); d0 = 8'($urandom);
               v1 = ($urandom_range(0, 19) == 0); d1 = 8'($urandom); end
      default: begin v0 = 1'b0; v1 = 1'b0; end
    endcase
    #1;
    full = (mq.size() == DEPTH);
`ifdef UART_TX_FIXED_PRIO_EN
    g0 = !full && v0;
    g1 = !full && v1 && !v0;
`else
    g0 = !full && v0 && (!v1 || lg);
    g1 = !full && v1 && (!v0 || !lg);
`endif
    chk("ready0", rdy0, g0);
    chk("ready1", rdy1, g1);
    chk("level", level, mq.size());
    chk("baud_en", baud_en, (e > 0) && (e % BD == 0));
    chk("send", send, fv && (e >= p) && (e <= s));
    chk("schar", schar, schar_m);
    chk("busy", busy, busy_m);
    if (rec && send && baud_en) begin
      tick_edges.push_back(e);
      sent.push_back(schar);
    end
    busy_m = (mq.size() > 0) || active(e);
    if (mq.size() > 0 && e + 1 >= free_e) begin
      schar_m = mq.pop_front();
      p       = e + 1;
      s       = ((p + BD - 1) / BD) * BD;
      free_e  = s + FT * BD + 2;
      fv      = 1'b1;
    end
    if (g0)      begin mq.push_back(d0); lg = 1'b0; end
    else if (g1) begin mq.push_back(d1); lg = 1'b1; end
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask

  task automatic start_rec();
    tick_edges.delete();
    sent.delete();
    rec = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    logic [7:0] got;
`ifdef UART_TX_FIXED_PRIO_EN
    exp_seq = '{8'h11, 8'h11, 8'h11, 8'h11};
`else
    exp_seq = '{8'h11, 8'h22, 8'h11, 8'h22};
`endif
    model_reset();

    // Reset, idle baud ticking, then a single req0 byte.
    apply_reset();
    repeat (12) step(0);
    start_rec();
    step(3);
    repeat (70) step(0);
    rec = 1'b0;
    chk("a5_frames", sent.size(), 1);
    got = (sent.size() > 0) ? sent[0] : 8'h00;
    chk("a5_byte", got, 8'hA5);

    // Both requesters valid continuously: alternation, FIFO fill, abutting frames.
    apply_reset();
    start_rec();
    repeat (30) step(1);
    chk("fill_level", level, 4);
    chk("fill_rdy0", rdy0, 1'b0);
    chk("fill_rdy1", rdy1, 1'b0);
    repeat (220) step(1);
    repeat (260) step(0);
    rec = 1'b0;
    chk("both_frames_ge4", sent.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      got = (i < sent.size()) ? sent[i] : 8'h00;
      chk($sformatf("both_byte%0d", i), got, exp_seq[i]);
    end
    for (int i = 1; i < tick_edges.size(); i++)
      chk($sformatf("tick_gap%0d", i), tick_edges[i] - tick_edges[i-1], (FT + 1) * BD);
    chk("drained_busy", busy, 1'b0);

    // Reset while BUSY with two bytes queued.
    apply_reset();
    repeat (5) step(0);
    repeat (3) step(4);
    repeat (20) step(0);
    chk("pre_rst_level", level, 2);
    chk("pre_rst_busy", busy, 1'b1);
    apply_reset();
    start_rec();
    repeat (80) step(0);
    rec = 1'b0;
    chk("post_rst_sends", sent.size(), 0);

    // Randomized traffic, sparse then dense.
    repeat (800) step(5);
    repeat (800) step(2);
    repeat (300) step(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
